// File: rtl/x1_bus_pkg.sv
// Shared definitions for the X1 video-memory bus: grant tags, arbitration
// defaults and WAIT_n polarity.
package x1_bus_pkg;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VID    = 2'd1,
    TAG_CPU_RD = 2'd2,
    TAG_CPU_WR = 2'd3
  } gnt_tag_e;

  localparam int MAX_VID_DEF = 4;

  // Z80 WAIT_n is active low: asserting it stalls the CPU.
  localparam logic WAIT_ASSERT  = 1'b0;
  localparam logic WAIT_RELEASE = 1'b1;

  function automatic logic is_cpu_tag(input gnt_tag_e t);
    return (t == TAG_CPU_RD) || (t == TAG_CPU_WR);
  endfunction

endpackage

// File: rtl/x1_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, a starvation counter
// bounds the CPU wait, and a two-stage tag pipe routes read data back.
module x1_vram_arbiter
  import x1_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int MAX_VID = MAX_VID_DEF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_valid,
  output logic [7:0]    vid_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_VID);

  logic          r_cpu_req_d;
  logic          r_cpu_pend;
  logic          r_cpu_we;
  logic [AW-1:0] r_cpu_addr;
  logic [7:0]    r_cpu_wdata;
  logic [3:0]    r_vid_run;
  logic [AW-1:0] r_last_addr;
  gnt_tag_e      r_tag1;
  logic [7:0]    r_cpu_rdata;
  logic          r_wait_n;
  logic          r_vid_valid;
  logic [7:0]    r_vid_rdata;

  logic          w_cpu_edge;
  logic          w_cpu_take;
  logic          w_vid_gnt;
  logic          w_cpu_gnt;
  gnt_tag_e      w_tag;
  logic [AW-1:0] w_mem_addr;
  logic          w_mem_we;

  assign w_cpu_edge = cpu_req & ~r_cpu_req_d;
  // An edge while an access is still pending is dropped so the latch stays intact.
  assign w_cpu_take = w_cpu_edge & ~r_cpu_pend;

  always_comb begin
    w_vid_gnt  = 1'b0;
    w_cpu_gnt  = 1'b0;
    w_tag      = TAG_NONE;
    w_mem_addr = r_last_addr;
    w_mem_we   = 1'b0;
    if (vid_req && !(r_cpu_pend && (r_vid_run == RUN_MAX))) begin
      w_vid_gnt  = 1'b1;
      w_tag      = TAG_VID;
      w_mem_addr = vid_addr;
    end else if (r_cpu_pend) begin
      w_cpu_gnt  = 1'b1;
      w_tag      = r_cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      w_mem_addr = r_cpu_addr;
      w_mem_we   = r_cpu_we;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_req_d <= 1'b0;
      r_cpu_pend  <= 1'b0;
      r_cpu_we    <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_wdata <= '0;
    end else begin
      r_cpu_req_d <= cpu_req;
      if (w_cpu_take) begin
        r_cpu_pend  <= 1'b1;
        r_cpu_we    <= cpu_we;
        r_cpu_addr  <= cpu_addr;
        r_cpu_wdata <= cpu_wdata;
      end else if (w_cpu_gnt) begin
        r_cpu_pend  <= 1'b0;
      end
    end
  end

  // Counts video grants that overtook a pending CPU access.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_run   <= '0;
      r_last_addr <= '0;
    end else begin
      if (!r_cpu_pend || w_cpu_gnt)
        r_vid_run <= '0;
      else if (w_vid_gnt && (r_vid_run != RUN_MAX))
        r_vid_run <= r_vid_run + 4'd1;
      if (w_vid_gnt || w_cpu_gnt)
        r_last_addr <= w_mem_addr;
    end
  end

  // tag1 marks the cycle mem_rdata is valid; the second stage registers results.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tag1      <= TAG_NONE;
      r_cpu_rdata <= '0;
      r_wait_n    <= WAIT_RELEASE;
      r_vid_valid <= 1'b0;
      r_vid_rdata <= '0;
    end else begin
      r_tag1      <= w_tag;
      r_vid_valid <= (r_tag1 == TAG_VID);
      if (r_tag1 == TAG_VID)
        r_vid_rdata <= mem_rdata;
      if (r_tag1 == TAG_CPU_RD)
        r_cpu_rdata <= mem_rdata;
      if (w_cpu_take)
        r_wait_n <= WAIT_ASSERT;
      else if (is_cpu_tag(r_tag1))
        r_wait_n <= WAIT_RELEASE;
    end
  end

  assign vid_gnt    = w_vid_gnt;
  assign mem_addr   = w_mem_addr;
  assign mem_we     = w_mem_we;
  assign mem_wdata  = r_cpu_wdata;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_wait_n = r_wait_n;
  assign vid_valid  = r_vid_valid;
  assign vid_rdata  = r_vid_rdata;

endmodule

// File: tb/tb_x1_vram_arbiter.sv
// Directed bench for x1_vram_arbiter with a behavioural 1-cycle-read VRAM.
module tb_x1_vram_arbiter;

  localparam int AW = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, vid_req;
  logic [AW-1:0] cpu_addr, vid_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata, vid_rdata, mem_wdata;
  logic          cpu_wait_n, vid_gnt, vid_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;

  logic [7:0] mem [0:65535];
  int n_tot = 0;
  int n_bad = 0;
  int we_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  x1_vram_arbiter #(.AW(AW), .MAX_VID(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_valid(vid_valid), .vid_rdata(vid_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Port-a dpram: registered read, write lands at the same edge.
  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk_sys) if (mem_we === 1'b1) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wn"},    32'(cpu_wait_n), 32'd1);
    chk({tag, "_crd"},   32'(cpu_rdata),  32'd0);
    chk({tag, "_gnt"},   32'(vid_gnt),    32'd0);
    chk({tag, "_vv"},    32'(vid_valid),  32'd0);
    chk({tag, "_vrd"},   32'(vid_rdata),  32'd0);
    chk({tag, "_we"},    32'(mem_we),     32'd0);
    chk({tag, "_addr"},  32'(mem_addr),   32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
  endtask

  initial begin
    logic [7:0] gnt_exp3, wn_exp3;
    gnt_exp3 = 8'b1101_1111;
    wn_exp3  = 8'b1000_0001;
    for (int k = 0; k < 8; k++) mem[k] = 8'(k) ^ 8'h3C;
    mem[16'h0123] = 8'h00;
    mem[16'h0300] = 8'h00;
    mem[16'h0456] = 8'h5A;
    reset_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    repeat (3) tick();
    #2; chk_reset_outs("rst0");
    tick(); reset_n = 1'b1;

    // CPU write then read of 0x0123 with idle video
    tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0123; cpu_wdata = 8'hA5; #2;
    chk("t1_edge_wn", 32'(cpu_wait_n), 32'd1);
    chk("t1_edge_we", 32'(mem_we), 32'd0);
    tick(); #2;
    chk("t1_g_wn", 32'(cpu_wait_n), 32'd0);
    chk("t1_g_we", 32'(mem_we), 32'd1);
    chk("t1_g_addr", 32'(mem_addr), 32'h0123);
    chk("t1_g_wdata", 32'(mem_wdata), 32'hA5);
    tick(); #2;
    chk("t1_p_wn", 32'(cpu_wait_n), 32'd0);
    chk("t1_p_we", 32'(mem_we), 32'd0);
    tick(); #2;
    chk("t1_done_wn", 32'(cpu_wait_n), 32'd1);
    tick(); cpu_req = 0; #2;
    tick(); cpu_req = 1; cpu_we = 0; #2;
    tick(); #2;
    chk("t1r_g_wn", 32'(cpu_wait_n), 32'd0);
    chk("t1r_g_addr", 32'(mem_addr), 32'h0123);
    chk("t1r_g_we", 32'(mem_we), 32'd0);
    tick(); #2;
    chk("t1r_p_wn", 32'(cpu_wait_n), 32'd0);
    tick(); #2;
    chk("t1r_done_wn", 32'(cpu_wait_n), 32'd1);
    chk("t1r_rdata", 32'(cpu_rdata), 32'hA5);
    chk("t1_we_cnt", 32'(we_cnt), 32'd1);

    // Video burst, addresses 0..7
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) cpu_req = 0;
      vid_req = (i < 8); vid_addr = 16'(i); #2;
      chk("t2_gnt", 32'(vid_gnt), 32'(i < 8));
      if (i < 8) chk("t2_addr", 32'(mem_addr), 32'(i));
      if (i >= 2 && i < 10) begin
        chk("t2_vv", 32'(vid_valid), 32'd1);
        chk("t2_vrd", 32'(vid_rdata), 32'((i - 2) ^ 8'h3C));
      end else
        chk("t2_vv_idle", 32'(vid_valid), 32'd0);
    end

    // Continuous video with a CPU read arriving alongside: starvation bound
    for (int c = 0; c < 8; c++) begin
      tick();
      vid_req = 1; vid_addr = 16'h0200 + 16'(c);
      if (c == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0456; end
      #2;
      chk("t3_gnt", 32'(vid_gnt), 32'(gnt_exp3[c]));
      chk("t3_wn", 32'(cpu_wait_n), 32'(wn_exp3[c]));
      if (c == 5) begin
        chk("t3_cpu_addr", 32'(mem_addr), 32'h0456);
        chk("t3_cpu_we", 32'(mem_we), 32'd0);
      end
      if (c == 7) chk("t3_rdata", 32'(cpu_rdata), 32'h5A);
    end

    // Simultaneous CPU edge and single video request
    tick(); vid_req = 0; cpu_req = 0; #2;
    tick(); vid_req = 1; vid_addr = 16'h0001;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 8'h77; #2;
    chk("t4_vgnt", 32'(vid_gnt), 32'd1);
    chk("t4_vaddr", 32'(mem_addr), 32'h0001);
    chk("t4_vwe", 32'(mem_we), 32'd0);
    tick(); vid_req = 0; #2;
    chk("t4_cgnt", 32'(vid_gnt), 32'd0);
    chk("t4_cwe", 32'(mem_we), 32'd1);
    chk("t4_caddr", 32'(mem_addr), 32'h0300);
    tick(); #2;
    chk("t4_vv", 32'(vid_valid), 32'd1);
    chk("t4_vrd", 32'(vid_rdata), 32'h3D);
    chk("t4_p_wn", 32'(cpu_wait_n), 32'd0);
    tick(); #2;
    chk("t4_done_wn", 32'(cpu_wait_n), 32'd1);
    chk("t4_mem", 32'(mem[16'h0300]), 32'h77);
    chk("t4_we_cnt", 32'(we_cnt), 32'd2);

    // cpu_req held high: no retrigger
    for (int i = 0; i < 20; i++) begin
      tick(); #2;
      chk("t5_wn", 32'(cpu_wait_n), 32'd1);
    end
    chk("t5_we_cnt", 32'(we_cnt), 32'd2);

    // Reset right after a CPU write edge abandons the write
    tick(); cpu_req = 0; #2;
    tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0123; cpu_wdata = 8'hFF; #2;
    tick(); reset_n = 0; cpu_req = 0; #2;
    chk_reset_outs("t6");
    tick(); tick(); reset_n = 1; #2;
    chk_reset_outs("t6_rel");
    tick(); tick(); #2;
    chk("t6_mem", 32'(mem[16'h0123]), 32'hA5);
    chk("t6_we_cnt", 32'(we_cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
